// File: rtl/fpu_pkg.sv
// Shared definitions for the float-to-int converter arbiter: FSM encoding,
// default operand width and a constant clog2 helper.
package fpu_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_ARB    = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RETURN = 3'd4
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/fpu_rr_pick.sv
// Combinational rotating-priority picker: scans last+1 .. NREQ-1, 0 .. last
// and returns the first requester with its bit set.
module fpu_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDX_W'((int'(last) + k) % NREQ);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/fpu_conv_arbiter.sv
// Round-robin arbiter sharing one stb/ack float-to-int converter between NREQ clients.
// Define FPU_ARB_STATS_EN to add per-requester completed-operation counters (grant_cnt).
module fpu_conv_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = DATA_W_DEF,
`ifdef FPU_ARB_STATS_EN
  parameter int CNT_W  = 16,
`endif
  localparam int IDX_W = clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ-1:0]        req_a_stb,
  output logic [NREQ-1:0]        req_a_ack,
  output logic [DATA_W-1:0]      rsp_z,
  output logic [NREQ-1:0]        rsp_z_stb,
  input  logic [NREQ-1:0]        rsp_z_ack,
  output logic [DATA_W-1:0]      conv_a,
  output logic                   conv_a_stb,
  input  logic                   conv_a_ack,
  input  logic [DATA_W-1:0]      conv_z,
  input  logic                   conv_z_stb,
  output logic                   conv_z_ack,
  output logic                   busy,
  output logic [IDX_W-1:0]       owner
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0]  grant_cnt
`endif
);

  state_t            state, next_state;
  logic [IDX_W-1:0]  last_grant, pick_idx, owner_d;
  logic              pick_any;
  logic [NREQ-1:0]   req_a_ack_d, rsp_z_stb_d;
  logic              conv_a_stb_d, conv_z_ack_d;
  logic [DATA_W-1:0] sel_a;
  logic              acc_xfer, iss_xfer, wait_xfer, ret_xfer;

  fpu_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req     (req_a_stb),
    .last    (last_grant),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign acc_xfer  = |(req_a_ack & req_a_stb);
  assign iss_xfer  = conv_a_stb & conv_a_ack;
  assign wait_xfer = conv_z_ack & conv_z_stb;
  // rsp_z_stb is one-hot to the owner, so acks from other requesters fall out here
  assign ret_xfer  = |(rsp_z_stb & rsp_z_ack);
  assign busy      = (state != ST_ARB);
  assign owner_d   = (state == ST_ARB && pick_any) ? pick_idx : owner;

  always_comb begin
    sel_a = '0;
    for (int i = 0; i < NREQ; i++)
      if (owner == IDX_W'(i)) sel_a = req_a[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ARB;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_ARB:    if (pick_any)  next_state = ST_ACCEPT;
      ST_ACCEPT: if (acc_xfer)  next_state = ST_ISSUE;
      ST_ISSUE:  if (iss_xfer)  next_state = ST_WAIT;
      ST_WAIT:   if (wait_xfer) next_state = ST_RETURN;
      ST_RETURN: if (ret_xfer)  next_state = ST_ARB;
      default:                  next_state = ST_ARB;
    endcase
  end

  // Handshake outputs are decoded from the next state so they come straight off flops
  always_comb begin
    req_a_ack_d  = '0;
    rsp_z_stb_d  = '0;
    conv_a_stb_d = 1'b0;
    conv_z_ack_d = 1'b0;
    case (next_state)
      ST_ACCEPT: req_a_ack_d  = NREQ'(1) << owner_d;
      ST_ISSUE:  conv_a_stb_d = 1'b1;
      ST_WAIT:   conv_z_ack_d = 1'b1;
      ST_RETURN: rsp_z_stb_d  = NREQ'(1) << owner_d;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= '0;
      last_grant <= IDX_W'(NREQ - 1);
      conv_a     <= '0;
      rsp_z      <= '0;
      req_a_ack  <= '0;
      rsp_z_stb  <= '0;
      conv_a_stb <= 1'b0;
      conv_z_ack <= 1'b0;
    end else begin
      owner      <= owner_d;
      req_a_ack  <= req_a_ack_d;
      rsp_z_stb  <= rsp_z_stb_d;
      conv_a_stb <= conv_a_stb_d;
      conv_z_ack <= conv_z_ack_d;
      if (state == ST_ACCEPT && acc_xfer) conv_a     <= sel_a;
      if (state == ST_WAIT && wait_xfer)  rsp_z      <= conv_z;
      if (state == ST_RETURN && ret_xfer) last_grant <= owner;
    end
  end

`ifdef FPU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (state == ST_RETURN && ret_xfer) begin
      for (int i = 0; i < NREQ; i++)
        if (owner == IDX_W'(i))
          grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fpu_conv_arbiter.sv
// Directed-vector bench for fpu_conv_arbiter with a behavioural stb/ack converter
// (truncating float-to-int) and per-requester client models.
module tb_fpu_conv_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ-1:0]   req_a_stb, req_a_ack, rsp_z_stb, rsp_z_ack;
  logic [DW-1:0]     rsp_z, conv_a, conv_z;
  logic              conv_a_stb, conv_a_ack, conv_z_stb, conv_z_ack, busy;
  logic [1:0]        owner;
`ifdef FPU_ARB_STATS_EN
  logic [NREQ*16-1:0] grant_cnt;
`endif

  fpu_conv_arbiter #(.NREQ(NREQ), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_a_stb(req_a_stb), .req_a_ack(req_a_ack),
    .rsp_z(rsp_z), .rsp_z_stb(rsp_z_stb), .rsp_z_ack(rsp_z_ack),
    .conv_a(conv_a), .conv_a_stb(conv_a_stb), .conv_a_ack(conv_a_ack),
    .conv_z(conv_z), .conv_z_stb(conv_z_stb), .conv_z_ack(conv_z_ack),
    .busy(busy), .owner(owner)
`ifdef FPU_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          req;
    logic [31:0] op;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[9];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] op_q[NREQ][$];
  logic [NREQ-1:0] pend = '0;
  logic [NREQ-1:0] hold = '0;
  int          acc_log[$];
  logic [3:0]  res_stb[$];
  logic [31:0] res_val[$];
  logic [1:0]  res_own[$];
  logic [31:0] conv_log[$];
  int          busy_err = 0;
  bit          rand_mode = 1'b0;
  int          z_delay_fix = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] f2i(input logic [31:0] f);
    logic [7:0]  e;
    logic [31:0] m;
    e = f[30:23];
    m = {8'h00, 1'b1, f[22:0]};
    if (e < 8'd127)       m = '0;
    else if (e >= 8'd150) m = m << (e - 8'd150);
    else                  m = m >> (8'd150 - e);
    if (f[31]) m = -m;
    return m;
  endfunction

  function automatic int pick_delay(input int fixed);
    return rand_mode ? int'($urandom_range(0, 20)) : fixed;
  endfunction

  // Converter model, held in reset by the same rst_n as the arbiter
  int          cv_state, cv_cnt;
  logic [31:0] cv_hold;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_state <= 0; cv_cnt <= 0; cv_hold <= '0;
      conv_a_ack <= 1'b0; conv_z_stb <= 1'b0; conv_z <= '0;
    end else begin
      case (cv_state)
        0: if (conv_a_ack && conv_a_stb) begin
             conv_a_ack <= 1'b0; cv_hold <= conv_a;
             cv_cnt <= pick_delay(z_delay_fix); cv_state <= 1;
           end else if (cv_cnt == 0) conv_a_ack <= 1'b1;
           else cv_cnt <= cv_cnt - 1;
        1: if (cv_cnt == 0) begin
             conv_z_stb <= 1'b1; conv_z <= f2i(cv_hold); cv_state <= 2;
           end else cv_cnt <= cv_cnt - 1;
        default: if (conv_z_stb && conv_z_ack) begin
             conv_z_stb <= 1'b0; cv_cnt <= pick_delay(0); cv_state <= 0;
           end
      endcase
    end
  end

  // Client models and transfer monitor, all evaluated on the falling edge
  initial begin
    req_a = '0; req_a_stb = '0; rsp_z_ack = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin req_a_stb[i] = 1'b0; pend[i] = 1'b0; end
        if (!req_a_stb[i] && op_q[i].size() > 0) begin
          req_a[i*DW +: DW] = op_q[i].pop_front();
          req_a_stb[i] = 1'b1;
        end
        if (req_a_stb[i] && req_a_ack[i]) begin pend[i] = 1'b1; acc_log.push_back(i); end
        rsp_z_ack[i] = !hold[i];
      end
      if ((rsp_z_stb & rsp_z_ack) != '0) begin
        res_stb.push_back(rsp_z_stb); res_val.push_back(rsp_z); res_own.push_back(owner);
      end
      if (conv_a_stb && conv_a_ack) conv_log.push_back(conv_a);
      if ((conv_a_stb || conv_z_ack) && !busy) busy_err++;
    end
  end

  task automatic clear_logs();
    acc_log.delete(); res_stb.delete(); res_val.delete(); res_own.delete(); conv_log.delete();
  endtask

  task automatic apply_stimulus(input int req, input logic [31:0] op);
    op_q[req].push_back(op);
  endtask

  task automatic wait_results(input int n, input int budget);
    int c = 0;
    while (res_val.size() < n && c < budget) begin @(negedge clk); c++; end
    if (res_val.size() < n) check_output("result_timeout", 32'(res_val.size()), 32'(n));
  endtask

  function automatic logic [31:0] val_at(input int k);
    return (k < res_val.size()) ? res_val[k] : 32'hDEADBEEF;
  endfunction
  function automatic logic [31:0] stb_at(input int k);
    return (k < res_stb.size()) ? 32'(res_stb[k]) : 32'hDEADBEEF;
  endfunction
  function automatic logic [31:0] acc_at(input int k);
    return (k < acc_log.size()) ? 32'(acc_log[k]) : 32'hDEADBEEF;
  endfunction
  function automatic logic [31:0] conv_at(input int k);
    return (k < conv_log.size()) ? conv_log[k] : 32'hDEADBEEF;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] snap;
    int          stable_err, c;

    vecs[0] = '{0, 32'h40490FDB, 32'h00000003};
    vecs[1] = '{1, 32'h42F60000, 32'h0000007B};
    vecs[2] = '{2, 32'hC1200000, 32'hFFFFFFF6};
    vecs[3] = '{3, 32'hBF800000, 32'hFFFFFFFF};
    vecs[4] = '{0, 32'h47C35000, 32'h000186A0};
    vecs[5] = '{0, 32'h3F000000, 32'h00000000};
    vecs[6] = '{1, 32'h41200000, 32'h0000000A};
    vecs[7] = '{2, 32'h40000000, 32'h00000002};
    vecs[8] = '{3, 32'hBF800000, 32'hFFFFFFFF};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_req_a_ack", 32'(req_a_ack), 32'h0);
    check_output("rst_rsp_z_stb", 32'(rsp_z_stb), 32'h0);
    check_output("rst_conv_hs", {30'd0, conv_a_stb, conv_z_ack}, 32'h0);
    check_output("rst_busy_owner", {29'd0, busy, owner}, 32'h0);
    check_output("rst_rsp_z", rsp_z, 32'h0);
    check_output("rst_conv_a", conv_a, 32'h0);
    rst_n = 1'b1;

    // Single operation from requester 0
    @(posedge clk); #1;
    clear_logs();
    apply_stimulus(0, 32'h40490FDB);
    wait_results(1, 100);
    check_output("t1_conv_operand", conv_at(0), 32'h40490FDB);
    check_output("t1_rsp_z", val_at(0), 32'h00000003);
    check_output("t1_rsp_stb", stb_at(0), 32'h1);
    check_output("t1_owner", (res_own.size() > 0) ? 32'(res_own[0]) : 32'hDEADBEEF, 32'h0);

    // All four requesters pending from reset: round-robin 0,1,2,3,0
    rst_n = 1'b0;
    clear_logs();
    for (int k = 0; k < 5; k++) apply_stimulus(vecs[k].req, vecs[k].op);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_results(5, 300);
    for (int k = 0; k < 5; k++) begin
      check_output($sformatf("t2_grant%0d", k), acc_at(k), 32'(vecs[k].req));
      check_output($sformatf("t2_stb%0d", k), stb_at(k), 32'(1 << vecs[k].req));
      check_output($sformatf("t2_val%0d", k), val_at(k), vecs[k].exp);
    end

    // Requester 1 withholds rsp_z_ack; requester 3 must wait
    @(posedge clk); #1;
    clear_logs();
    hold[1] = 1'b1;
    apply_stimulus(1, 32'h41200000);
    apply_stimulus(3, 32'h42F60000);
    c = 0;
    while (!rsp_z_stb[1] && c < 100) begin @(negedge clk); c++; end
    check_output("t3_reached_return", 32'(rsp_z_stb), 32'h2);
    snap = rsp_z;
    stable_err = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_z !== snap || rsp_z_stb !== 4'b0010 || req_a_ack !== 4'b0000 || !busy)
        stable_err++;
    end
    check_output("t3_hold_stable", 32'(stable_err), 32'h0);
    check_output("t3_hold_value", snap, 32'h0000000A);
    hold[1] = 1'b0;
    wait_results(2, 100);
    check_output("t3_next_grant", acc_at(1), 32'h3);
    check_output("t3_req3_val", val_at(1), 32'h0000007B);
    check_output("t3_req3_stb", stb_at(1), 32'h8);

    // Randomly stalling converter
    @(posedge clk); #1;
    clear_logs();
    busy_err = 0;
    rand_mode = 1'b1;
    for (int k = 5; k < 9; k++) apply_stimulus(vecs[k].req, vecs[k].op);
    wait_results(4, 600);
    rand_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_output("t4_conv_count", 32'(conv_log.size()), 32'h4);
    check_output("t4_result_count", 32'(res_val.size()), 32'h4);
    for (int k = 5; k < 9; k++) begin
      check_output($sformatf("t4_operand%0d", k), conv_at(k - 5), vecs[k].op);
      check_output($sformatf("t4_val%0d", k), val_at(k - 5), vecs[k].exp);
      check_output($sformatf("t4_stb%0d", k), stb_at(k - 5), 32'(1 << vecs[k].req));
    end
    check_output("t4_busy_during_conv", 32'(busy_err), 32'h0);

    // Asynchronous reset in the middle of WAIT
    clear_logs();
    z_delay_fix = 30;
    apply_stimulus(2, 32'h40000000);
    c = 0;
    while (!conv_z_ack && c < 100) begin @(negedge clk); c++; end
    check_output("t5_reached_wait", {31'd0, conv_z_ack}, 32'h1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_output("t5_hs_dropped", {22'd0, req_a_ack, rsp_z_stb, conv_a_stb, conv_z_ack}, 32'h0);
    check_output("t5_owner_busy", {29'd0, busy, owner}, 32'h0);
    z_delay_fix = 0;
    repeat (2) @(negedge clk);
    clear_logs();
    apply_stimulus(2, 32'h40000000);
    apply_stimulus(0, 32'hC1200000);
    @(negedge clk);
    rst_n = 1'b1;
    wait_results(2, 100);
    check_output("t5_first_grant", acc_at(0), 32'h0);
    check_output("t5_first_val", val_at(0), 32'hFFFFFFF6);
    check_output("t5_second_grant", acc_at(1), 32'h2);

`ifdef FPU_ARB_STATS_EN
    // Completed-operation counters
    rst_n = 1'b0;
    clear_logs();
    repeat (2) @(negedge clk);
    check_output("t6_cnt_reset", 32'(grant_cnt[2*16 +: 16]), 32'h0);
    for (int k = 0; k < 3; k++) apply_stimulus(2, vecs[7].op);
    apply_stimulus(0, vecs[0].op);
    @(negedge clk);
    rst_n = 1'b1;
    wait_results(4, 200);
    repeat (2) @(negedge clk);
    check_output("t6_cnt0", 32'(grant_cnt[0*16 +: 16]), 32'h1);
    check_output("t6_cnt1", 32'(grant_cnt[1*16 +: 16]), 32'h0);
    check_output("t6_cnt2", 32'(grant_cnt[2*16 +: 16]), 32'h3);
    check_output("t6_cnt3", 32'(grant_cnt[3*16 +: 16]), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
